// File: rtl/tri_fetch_sequencer.sv
// rtl/tri_fetch_sequencer.sv - triangle record fetch sequencer with 2-entry credit-based output buffer
// Optional abort input enabled by macro TRI_FETCH_ABORT_EN.
module tri_fetch_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int VERT_W  = 54,
  parameter int COLOR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    tri_count,
`ifdef TRI_FETCH_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  read_addr,
  input  logic [VERT_W-1:0]  v1_q,
  input  logic [VERT_W-1:0]  v2_q,
  input  logic [VERT_W-1:0]  v3_q,
  input  logic [VERT_W-1:0]  normal_q,
  input  logic [COLOR_W-1:0] color_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_index,
  output logic [VERT_W-1:0]  out_v1,
  output logic [VERT_W-1:0]  out_v2,
  output logic [VERT_W-1:0]  out_v3,
  output logic [VERT_W-1:0]  out_normal,
  output logic [COLOR_W-1:0] out_color
);

  typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  index;
    logic [VERT_W-1:0]  v1;
    logic [VERT_W-1:0]  v2;
    logic [VERT_W-1:0]  v3;
    logic [VERT_W-1:0]  nrm;
    logic [COLOR_W-1:0] color;
  } rec_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   total, issued;
  logic [ADDR_W-1:0] idx, tag;
  logic [1:0]        count;
  logic              pending;
  rec_t              head, tail, push_rec;
  logic              pop, push, issue, abort_hit, start_hit, finish;
  logic [2:0]        occupancy;

`ifdef TRI_FETCH_ABORT_EN
  assign abort_hit = (state == RUN) & abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign start_hit = (state == IDLE) & start;
  assign pop       = (count != 2'd0) & out_ready;
  assign push      = pending;
  // Credit: entries held plus the read in flight, after this cycle's pop, must leave room.
  assign occupancy = {1'b0, count} + {2'b0, pending} - {2'b0, pop};
  assign issue     = (state == RUN) & ~abort_hit & (issued < total) & (occupancy < 3'(DEPTH));
  // Last record leaves this cycle (or none ever existed) and nothing is in flight.
  assign finish    = (issued == total) & ~pending &
                     ((count == 2'd0) | ((count == 2'd1) & pop));
  assign push_rec  = '{index: tag, v1: v1_q, v2: v2_q, v3: v3_q, nrm: normal_q, color: color_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (abort_hit)   state_next = IDLE;
        else if (finish) state_next = DONE_S;
      end
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE_S);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      total   <= '0;
      issued  <= '0;
      idx     <= '0;
      tag     <= '0;
      pending <= 1'b0;
    end else begin
      if (start_hit) begin
        total  <= tri_count;
        issued <= '0;
        idx    <= '0;
      end else if (issue) begin
        idx    <= idx + 1'b1;
        issued <= issued + 1'b1;
        tag    <= idx;
      end
      pending <= issue;
    end
  end

  // Head/tail shift buffer: head always drives the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (abort_hit) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_rec;
          else               tail <= push_rec;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_rec;
          end else begin
            head <= tail;
            tail <= push_rec;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_addr  = idx;
  assign out_valid  = (count != 2'd0);
  assign out_index  = head.index;
  assign out_v1     = head.v1;
  assign out_v2     = head.v2;
  assign out_v3     = head.v3;
  assign out_normal = head.nrm;
  assign out_color  = head.color;

endmodule

// File: tb/tb_tri_fetch_sequencer.sv
// tb/tb_tri_fetch_sequencer.sv - self-checking bench for tri_fetch_sequencer
module tb_tri_fetch_sequencer;
  localparam int AW = 12;
  localparam int VW = 54;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW:0]   tri_count = '0;
`ifdef TRI_FETCH_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy, done, out_valid;
  logic [AW-1:0] read_addr, out_index;
  logic [VW-1:0] v1_q, v2_q, v3_q, normal_q;
  logic [VW-1:0] out_v1, out_v2, out_v3, out_normal;
  logic [CW-1:0] color_q, out_color;
  logic [AW-1:0] ram_a = '0;

  int checks = 0;
  int errors = 0;

  tri_fetch_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .tri_count(tri_count),
`ifdef TRI_FETCH_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .read_addr(read_addr),
    .v1_q(v1_q), .v2_q(v2_q), .v3_q(v3_q), .normal_q(normal_q), .color_q(color_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_v1(out_v1), .out_v2(out_v2), .out_v3(out_v3), .out_normal(out_normal),
    .out_color(out_color)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] fv(input logic [AW-1:0] a, input int k);
    return {6'(k), 36'(a) * 36'd977, a};
  endfunction

  function automatic logic [CW-1:0] fc(input logic [AW-1:0] a);
    return 16'(a) * 16'd3 + 16'd5;
  endfunction

  // Synchronous-read RAM model: one cycle from address to data.
  always @(posedge clock) ram_a <= read_addr;
  always_comb begin
    v1_q     = fv(ram_a, 1);
    v2_q     = fv(ram_a, 2);
    v3_q     = fv(ram_a, 3);
    normal_q = fv(ram_a, 4);
    color_q  = fc(ram_a);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_record(input int i);
    logic [AW-1:0] a;
    a = AW'(i);
    chk("out_index", 64'(out_index), 64'(a));
    chk("out_v1", 64'(out_v1), 64'(fv(a, 1)));
    chk("out_v2", 64'(out_v2), 64'(fv(a, 2)));
    chk("out_v3", 64'(out_v3), 64'(fv(a, 3)));
    chk("out_normal", 64'(out_normal), 64'(fv(a, 4)));
    chk("out_color", 64'(out_color), 64'(fc(a)));
  endtask

  // mode 0: ready always, 1: random ready, 2: toggle 1,0,..., 3: ready low 6 cycles then high
  task automatic run_pass(input int n, input int mode);
    int exp_idx, last_pop, budget, cyc;
    bit done_seen;
    exp_idx = 0; last_pop = -1; done_seen = 0; budget = 8 * n + 20;
    tri_count = (AW+1)'(n);
    start = 1'b1;
    chk("idle_busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    for (cyc = 1; cyc < budget && !done_seen; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = ((cyc % 2) == 1);
        default: out_ready = (cyc > 6);
      endcase
      chk("busy_run", 64'(busy), 64'd1);
      if (mode == 0 && n > 0)
        chk("read_addr_seq", 64'(read_addr), 64'(((cyc - 1) < n) ? (cyc - 1) : n));
      chk("credit_le2", 64'((int'(read_addr) - exp_idx) <= 2), 64'd1);
      if (mode == 3 && cyc == 6) begin
        chk("park_addr", 64'(read_addr), 64'd2);
        chk("park_valid", 64'(out_valid), 64'd1);
        chk("park_head", 64'(out_index), 64'd0);
      end
      if (out_valid && out_ready) begin
        chk("pop_in_range", 64'(exp_idx < n), 64'd1);
        chk_record(exp_idx);
        exp_idx++;
        last_pop = cyc;
      end
      if (done) begin
        done_seen = 1;
        chk("all_delivered", 64'(exp_idx), 64'(n));
        chk("done_timing", 64'(cyc), 64'((n == 0) ? 2 : last_pop + 1));
        if (mode == 0 && n > 0) chk("done_cycle", 64'(cyc), 64'(n + 3));
      end
      tick();
    end
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_done", 64'(done), 64'd0);
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_addr", 64'(read_addr), 64'(n % 4096));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", 64'(read_addr), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_v1", 64'(out_v1), 64'd0);
    chk("rst_color", 64'(out_color), 64'd0);
    reset = 1'b0;
    tick();

    run_pass(4, 0);
    run_pass(5, 3);
    run_pass(0, 0);
    run_pass(3, 2);

    // Reset with a full buffer.
    tri_count = 13'd8;
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_addr", 64'(read_addr), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_addr", 64'(read_addr), 64'd0);
    chk("mid_rst_index", 64'(out_index), 64'd0);
    chk("mid_rst_v2", 64'(out_v2), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_pass(6, 0);

`ifdef TRI_FETCH_ABORT_EN
    tri_count = 13'd10;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    chk("abort_busy", 64'(busy), 64'd1);
    tick();
    abort = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      tick();
    end
    run_pass(2, 0);
`endif

    for (int p = 0; p < 6; p++) run_pass(int'($urandom_range(1, 20)), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tri_fetch_sequencer.md
Name: tri_fetch_sequencer

Overview:
- Walks triangle indices 0..tri_count-1 over the shared 12-bit read address of the per-triangle RAMs (V1, V2, V3, normal, color).
- The RAMs have 1-cycle synchronous read latency. The block captures their q outputs and presents one triangle record per index to the downstream projection/raster stage over a valid/ready handshake.
- A 2-entry output buffer with credit-based issue sustains 1 triangle/cycle when downstream is always ready.

Parameters:
- ADDR_W, 12, triangle index / RAM address width.
- VERT_W, 54, width of one vertex or normal word (3 x 18-bit fixed point).
- COLOR_W, 16, color word width.
- DEPTH, 2, output buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  pulse to begin a pass; sampled only in IDLE.
- tri_count  in  ADDR_W+1  number of triangles, 0..4096; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse at end of pass.
- read_addr  out  ADDR_W  address driven to all five RAMs; direct register output.
- v1_q, v2_q, v3_q, normal_q  in  VERT_W  RAM read data.
- color_q  in  COLOR_W  RAM read data.
- out_valid  out  1  head-of-buffer record valid.
- out_ready  in  1  downstream accept.
- out_index  out  ADDR_W  triangle index of the head record.
- out_v1, out_v2, out_v3, out_normal  out  VERT_W  head record fields.
- out_color  out  COLOR_W  head record field.

Behaviour:
- Reset (async, immediate): state=IDLE; idx, read_addr, count, pending, issued all 0. busy=0, done=0, out_valid=0, all out_* data 0.
- States:
  - IDLE: start accepted → RUN. tri_count latched to total, idx=0.
  - RUN: issues reads until issued==total, then drains.
  - DONE: one cycle; done=1, busy=1 → IDLE.
- tri_count=0: start → RUN with issued==total. No read is issued. Next cycle → DONE.
- pop = out_valid & out_ready.
- issue (combinational, RUN only) = (issued<total) & (count + pending - pop < 2).
- Issue in cycle t:
  - read_addr=idx is presented during t; the RAMs sample at end of t.
  - At end of t: idx++, issued++, pending set to 1, and the tag register records idx.
- Cycle t+1: q is valid. At end of t+1 the record {tag, v1_q, v2_q, v3_q, normal_q, color_q} is pushed into the buffer. pending clears unless another issue occurs that cycle.
- Buffer:
  - 2-entry FIFO, head drives out_*.
  - out_valid = count!=0.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push never occurs when count==2; the credit rule guarantees this.
- Latency: start→first read_addr presentation is 1 cycle. Issue→out_valid is 2 cycles.
- Steady state with out_ready=1: one record per cycle, indices strictly increasing, none skipped or duplicated.
- Backpressure (out_ready=0):
  - Issue stops once count+pending reaches 2.
  - read_addr holds the next unissued index.
  - Head data stays stable while out_valid=1 and out_ready=0.
- RUN → DONE when issued==total, pending==0, count==0 (the last pop has completed).
- busy=1 in RUN and DONE. start while busy is ignored.
- read_addr after a pass ends holds total (a 4096 pass wraps the register to 0); no read is issued.
- Reset mid-pass: everything is discarded immediately; no done pulse.

Optional Feature:
Macro TRI_FETCH_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in RUN:
  - Issue is blocked that cycle.
  - At end of cycle: count=0, pending=0, any in-flight RAM data is dropped, state→IDLE.
  - No done pulse; out_valid falls the next cycle.
  - abort in IDLE or DONE is ignored. abort and start in the same IDLE cycle: start wins.
- Not defined: no abort port. A pass always runs to completion or reset.

Test Plan:
- tri_count=4, out_ready=1, RAM model returns data=addr → read_addr 0,1,2,3 on consecutive cycles; out_valid in 4 consecutive cycles with out_index 0..3 and fields matching; done pulses exactly once, 1 cycle after last pop; busy low next cycle.
- tri_count=5, out_ready held 0 for 6 cycles then 1 → exactly 2 reads issued (read_addr parks at 2); head out_index=0 stable; after release, indices 0..4 delivered in order without loss or duplication.
- tri_count=0 → no out_valid, done pulse 2 cycles after start, read_addr stays 0.
- tri_count=3, out_ready toggling 1,0,1,0 → every pop matches the expected index sequence; count never exceeds 2 (assertion).
- Reset asserted mid-pass with count=2 → outputs immediately 0; a new start then runs cleanly from index 0.
- TRI_FETCH_ABORT_EN: tri_count=10, abort at 4th cycle of RUN → IDLE next cycle, no done pulse; a subsequent start with tri_count=2 delivers indices 0,1.
